data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
Two-port arbiter and sequencer in front of the 16-bit data memory (128 bytes, big-endian byte pairs, registered read). It shares the memory between the CPU load/store port and a DMA/debug port using round-robin arbitration. It also checks alignment and range, drives the memory strobes for exactly one cycle per access, and returns read data or a write acknowledge with a one-cycle done pulse.

Parameters:
DATA_W, 16, data word width
ADDR_W, 16, byte address width
MEM_BYTES, 128, memory size in bytes; the highest legal word address is MEM_BYTES-2

Ports:
Clock  in  1  system clock, rising edge
Reset_n  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU access request; held until cpu_gnt
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  byte address
cpu_wdata  in  DATA_W  write data
cpu_gnt  out  1  one-cycle accept pulse
cpu_done  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  read data, valid while cpu_done=1 and the access was a read
cpu_err  out  1  valid with cpu_done; access was rejected
dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_done, dma_rdata, dma_err  same widths and semantics as the cpu_* ports
mem_Adresa  out  ADDR_W  memory address
mem_WriteData  out  DATA_W  memory write data
mem_MemWrite  out  1  memory write strobe
mem_MemRead  out  1  memory read strobe
mem_ReadData  in  DATA_W  memory read data, registered inside the memory
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - State goes to IDLE; all outputs go to 0.
  - last_grant goes to DMA, so the CPU wins the first tie.
  - An in-flight access is aborted: no done pulse, strobes drop immediately.
- FSM states: IDLE, ISSUE, RESP, FIN, ERR.
- IDLE, with at least one request:
  - Pick the winner. A lone requester wins. If both request, the winner is the port that is not last_grant.
  - Pulse the winner's gnt for one cycle and update last_grant.
  - Capture we, addr, wdata and the owner.
  - If the address is legal, go to ISSUE.
  - If addr[0]=1 or addr > MEM_BYTES-2, go to ERR.
- ISSUE (one cycle):
  - mem_Adresa and mem_WriteData are driven from the captured values.
  - mem_MemWrite = we, mem_MemRead = !we.
  - The memory acts on the edge that ends this cycle. Next state is RESP.
- RESP (one cycle):
  - Strobes are 0; mem_Adresa is held.
  - On a read, mem_ReadData is valid this cycle and is registered into the owner's rdata at the end of the cycle.
  - Next state is FIN.
- FIN (one cycle):
  - owner_done=1; owner_err=0.
  - rdata holds the read value. On a write, rdata is unchanged.
  - Next state is IDLE.
- ERR (one cycle):
  - owner_done=1 and owner_err=1. No memory strobe is ever asserted for a rejected access.
  - Next state is IDLE.
- Latency, measured from gnt in cycle T:
  - Legal access: done in cycle T+3; throughput is one access per 4 cycles.
  - Rejected access: done in cycle T+1.
- Handshake rules:
  - req, we, addr and wdata must be stable from req rise until gnt. They are don't-care after gnt.
  - A requester may drop req before gnt; that request is lost, with no error.
  - The loser of a tie keeps req high and is granted in the next IDLE cycle, so a continuously requesting port is never starved.
- Simultaneous events:
  - A new req arriving during ISSUE, RESP, FIN or ERR waits for IDLE.
  - The done pulse and the next gnt never occur in the same cycle.
- Outputs never carry X after reset. The non-owner's done, err and rdata stay unchanged during another port's access.

Test Plan:
- CPU write 0xBEEF to address 0x0010 -> gnt at T, mem_MemWrite=1 only at T+1, cpu_done=1 at T+3 with cpu_err=0; memory bytes 0x10=0xBE and 0x11=0xEF.
- DMA read of 0x0010 after that write -> mem_MemRead=1 for one cycle, dma_done at T+3 with dma_rdata=0xBEEF; cpu_done stays 0.
- cpu_req and dma_req both high from reset, each issuing 3 reads -> grants alternate CPU, DMA, CPU, DMA, CPU, DMA; each gnt is 4 cycles apart.
- CPU read of 0x0011 (odd) and of 0x007F (out of range, MEM_BYTES=128) -> cpu_done with cpu_err=1 one cycle after gnt; mem_MemRead and mem_MemWrite never rise.
- Address 0x007E (last legal word) -> access succeeds with err=0.
- Reset_n=0 asserted during RESP of a CPU read -> strobes and busy drop asynchronously, no cpu_done; after release, a pending tie grants the CPU first.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//
// Shares a 16-bit data memory (MEM_BYTES bytes, big-endian byte pairs,
// registered read) between a CPU load/store port and a DMA/debug port.
//
// Each access is one pass through IDLE -> ISSUE -> RESP -> FIN, or
// IDLE -> ERR when the address is odd or beyond the last word. The gnt pulse
// is issued combinationally in the IDLE cycle that accepts the request, the
// memory strobe is driven for exactly one cycle (ISSUE), and the owner gets a
// one-cycle done pulse (with err for rejected accesses). Ties are broken
// round-robin against the last granted port.
//
// Ports:
//   Clock, Reset_n          rising-edge clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata   CPU request, held until cpu_gnt
//   cpu_gnt                 one-cycle accept pulse
//   cpu_done/err/rdata      completion pulse, reject flag, read data
//   dma_*                   identical set for the DMA/debug port
//   mem_Adresa/WriteData    memory address and write data
//   mem_MemWrite/MemRead    one-cycle memory strobes
//   mem_ReadData            memory read data (registered inside the memory)
//   busy                    high whenever an access is in progress
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int MEM_BYTES = 128
) (
    input  logic              Clock,
    input  logic              Reset_n,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_done,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_err,

    output logic [ADDR_W-1:0] mem_Adresa,
    output logic [DATA_W-1:0] mem_WriteData,
    output logic              mem_MemWrite,
    output logic              mem_MemRead,
    input  logic [DATA_W-1:0] mem_ReadData,

    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        RESP,
        FIN,
        ERR
    } state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

    localparam logic [ADDR_W-1:0] LAST_WORD_ADDR = ADDR_W'(MEM_BYTES - 2);

    state_t            state_q,      state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q,      owner_d;
    logic              we_q,         we_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [DATA_W-1:0] wdata_q,      wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q,  cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q,  dma_rdata_d;

    logic              grant_cpu;
    logic              grant_dma;
    logic [ADDR_W-1:0] sel_addr;
    logic              addr_legal;

    // Arbitration: only decided in IDLE. On a tie the port that was not
    // granted last wins, so a port that keeps req high cannot be starved.
    always_comb begin : arbitrate
        grant_cpu = 1'b0;
        grant_dma = 1'b0;
        if (state_q == IDLE) begin
            if (cpu_req && (!dma_req || last_grant_q == OWNER_DMA)) begin
                grant_cpu = 1'b1;
            end else if (dma_req) begin
                grant_dma = 1'b1;
            end
        end
        sel_addr   = grant_dma ? dma_addr : cpu_addr;
        addr_legal = !sel_addr[0] && (sel_addr <= LAST_WORD_ADDR);
    end

    // Next-state logic.
    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_cpu || grant_dma) begin
                    state_d = addr_legal ? ISSUE : ERR;
                end
            end
            ISSUE:   state_d = RESP;
            RESP:    state_d = FIN;
            FIN:     state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture and read-data return.
    always_comb begin : datapath
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        dma_rdata_d  = dma_rdata_q;

        if (grant_cpu || grant_dma) begin
            last_grant_d = grant_dma;
            owner_d      = grant_dma;
            we_d         = grant_dma ? dma_we    : cpu_we;
            addr_d       = sel_addr;
            wdata_d      = grant_dma ? dma_wdata : cpu_wdata;
        end

        // The memory registered the read on the edge that ended ISSUE, so its
        // data is valid during RESP; only the owner's rdata register moves.
        if (state_q == RESP && !we_q) begin
            if (owner_q == OWNER_DMA) begin
                dma_rdata_d = mem_ReadData;
            end else begin
                cpu_rdata_d = mem_ReadData;
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // values from before the edge, independent of block evaluation order.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= OWNER_DMA;
            owner_q      <= OWNER_CPU;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    // Output decode: everything is a function of the registered state, so an
    // asynchronous reset drops strobes, done and busy immediately.
    always_comb begin : outputs
        // NOTE: gnt is combinational from the IDLE state, which is also the
        // reset state; masking with Reset_n keeps it low while a request is
        // held through reset. The mask is applied only here, never in the
        // flop inputs, so Reset_n stays purely an asynchronous reset there.
        cpu_gnt       = grant_cpu && Reset_n;
        dma_gnt       = grant_dma && Reset_n;

        cpu_done      = (state_q == FIN || state_q == ERR) && (owner_q == OWNER_CPU);
        dma_done      = (state_q == FIN || state_q == ERR) && (owner_q == OWNER_DMA);
        cpu_err       = (state_q == ERR) && (owner_q == OWNER_CPU);
        dma_err       = (state_q == ERR) && (owner_q == OWNER_DMA);
        cpu_rdata     = cpu_rdata_q;
        dma_rdata     = dma_rdata_q;

        mem_MemWrite  = (state_q == ISSUE) &&  we_q;
        mem_MemRead   = (state_q == ISSUE) && !we_q;
        mem_Adresa    = (state_q == ISSUE || state_q == RESP) ? addr_q : '0;
        mem_WriteData = (state_q == ISSUE) ? wdata_q : '0;

        busy          = (state_q != IDLE);
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
//
// Drives both ports of data_mem_arbiter, hosts a 128-byte big-endian memory
// with registered read, and compares every cycle against a timeline model:
// a grant at cycle g of a legal access means strobe at g+1, done at g+3 and
// the next grant no earlier than g+4; a rejected access completes at g+1 and
// frees the arbiter at g+2. Directed accesses pin the model with literal
// expectations before a randomized two-port phase.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 16;
    localparam int MEM_BYTES = 128;

    logic              Clock   = 1'b0;
    logic              Reset_n = 1'b0;

    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_gnt, cpu_done, cpu_err;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dma_req = 1'b0, dma_we = 1'b0;
    logic [ADDR_W-1:0] dma_addr = '0;
    logic [DATA_W-1:0] dma_wdata = '0;
    logic              dma_gnt, dma_done, dma_err;
    logic [DATA_W-1:0] dma_rdata;

    logic [ADDR_W-1:0] mem_Adresa;
    logic [DATA_W-1:0] mem_WriteData;
    logic              mem_MemWrite, mem_MemRead;
    logic [DATA_W-1:0] mem_ReadData = '0;
    logic              busy;

    always #5 Clock = ~Clock;

    data_mem_arbiter #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .MEM_BYTES(MEM_BYTES)
    ) dut (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_gnt      (cpu_gnt),
        .cpu_done     (cpu_done),
        .cpu_rdata    (cpu_rdata),
        .cpu_err      (cpu_err),
        .dma_req      (dma_req),
        .dma_we       (dma_we),
        .dma_addr     (dma_addr),
        .dma_wdata    (dma_wdata),
        .dma_gnt      (dma_gnt),
        .dma_done     (dma_done),
        .dma_rdata    (dma_rdata),
        .dma_err      (dma_err),
        .mem_Adresa   (mem_Adresa),
        .mem_WriteData(mem_WriteData),
        .mem_MemWrite (mem_MemWrite),
        .mem_MemRead  (mem_MemRead),
        .mem_ReadData (mem_ReadData),
        .busy         (busy)
    );

    // Data memory attached to the DUT: big-endian pairs, registered read.
    logic [7:0] phys_mem [MEM_BYTES];

    always @(posedge Clock) begin
        if (mem_MemWrite) begin
            phys_mem[{mem_Adresa[6:1], 1'b0}] <= mem_WriteData[15:8];
            phys_mem[{mem_Adresa[6:1], 1'b1}] <= mem_WriteData[7:0];
        end
        if (mem_MemRead) begin
            mem_ReadData <= {phys_mem[{mem_Adresa[6:1], 1'b0}], phys_mem[{mem_Adresa[6:1], 1'b1}]};
        end
    end

    // Bookkeeping
    int n_checks = 0;
    int n_pass   = 0;
    int pcyc     = 0;

    always @(posedge Clock) pcyc <= pcyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        $display("FAIL %s: got no event within the cycle budget, required one", name);
    endtask

    task automatic set_port(input bit is_dma, input logic req, input logic we,
                            input logic [15:0] addr, input logic [15:0] wdata);
        if (is_dma) begin
            dma_req = req; dma_we = we; dma_addr = addr; dma_wdata = wdata;
        end else begin
            cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
    endtask

    // Reference model state (timeline of the single in-flight access)
    logic [7:0]  ref_mem [MEM_BYTES];
    logic [15:0] exp_rd [2];
    bit          m_last_dma = 1'b1;
    int          next_free  = 0;
    bit          acc_v = 1'b0, acc_dma, acc_we, acc_legal;
    logic [15:0] acc_addr, acc_wdata;
    int          acc_g;
    int          mcyc = 0;

    // Monitor counters for the directed tests
    int wr_cnt = 0, rd_cnt = 0, last_wr_cyc = -1, last_rd_cyc = -1, cpu_done_cnt = 0;
    bit gq_port [$];
    int gq_cyc  [$];

    // Compare process: one pass per cycle at the falling edge.
    initial begin
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        forever begin
            logic e_cg, e_dg, e_cd, e_dd, e_ce, e_de, e_mw, e_mr, e_bz;
            int   d;
            @(negedge Clock);
            mcyc++;
            {e_cg, e_dg, e_cd, e_dd, e_ce, e_de, e_mw, e_mr, e_bz} = '0;

            if (!Reset_n) begin
                acc_v      = 1'b0;
                m_last_dma = 1'b1;
                next_free  = 0;
                exp_rd[0]  = '0;
                exp_rd[1]  = '0;
            end else if (mcyc >= next_free && (cpu_req || dma_req)) begin
                acc_dma    = dma_req && (!cpu_req || !m_last_dma);
                m_last_dma = acc_dma;
                acc_we     = acc_dma ? dma_we    : cpu_we;
                acc_addr   = acc_dma ? dma_addr  : cpu_addr;
                acc_wdata  = acc_dma ? dma_wdata : cpu_wdata;
                acc_legal  = (acc_addr % 2 == 0) && (int'(acc_addr) <= MEM_BYTES - 2);
                acc_g      = mcyc;
                acc_v      = 1'b1;
                next_free  = mcyc + (acc_legal ? 4 : 2);
                if (acc_dma) e_dg = 1'b1; else e_cg = 1'b1;
            end else if (acc_v) begin
                d = mcyc - acc_g;
                if (mcyc >= next_free) begin
                    acc_v = 1'b0;
                end else begin
                    e_bz = 1'b1;
                    if (acc_legal && d == 1) begin
                        e_mw = acc_we;
                        e_mr = !acc_we;
                        if (acc_we) begin
                            ref_mem[int'(acc_addr)]     = acc_wdata[15:8];
                            ref_mem[int'(acc_addr) + 1] = acc_wdata[7:0];
                        end
                    end
                    if (acc_legal && d == 3) begin
                        if (acc_dma) e_dd = 1'b1; else e_cd = 1'b1;
                        if (!acc_we)
                            exp_rd[acc_dma] = {ref_mem[int'(acc_addr)], ref_mem[int'(acc_addr) + 1]};
                    end
                    if (!acc_legal && d == 1) begin
                        if (acc_dma) begin e_dd = 1'b1; e_de = 1'b1; end
                        else         begin e_cd = 1'b1; e_ce = 1'b1; end
                    end
                end
            end

            check($sformatf("cycle_%0d {gnt,done,err,strobes,busy,rdata}", pcyc),
                  {cpu_gnt, dma_gnt, cpu_done, dma_done, cpu_err & cpu_done, dma_err & dma_done,
                   mem_MemWrite, mem_MemRead, busy, cpu_rdata, dma_rdata},
                  {e_cg, e_dg, e_cd, e_dd, e_ce, e_de, e_mw, e_mr, e_bz, exp_rd[0], exp_rd[1]});
            if (e_mw || e_mr) check($sformatf("cycle_%0d mem_Adresa", pcyc), mem_Adresa, acc_addr);
            if (e_mw)         check($sformatf("cycle_%0d mem_WriteData", pcyc), mem_WriteData, acc_wdata);

            if (mem_MemWrite) begin wr_cnt++; last_wr_cyc = pcyc; end
            if (mem_MemRead)  begin rd_cnt++; last_rd_cyc = pcyc; end
            if (cpu_done) cpu_done_cnt++;
            if (cpu_gnt) begin gq_port.push_back(1'b0); gq_cyc.push_back(pcyc); end
            if (dma_gnt) begin gq_port.push_back(1'b1); gq_cyc.push_back(pcyc); end
        end
    end

    // One complete access on one port; returns grant/done cycles and results.
    task automatic do_access(input bit is_dma, input bit we, input logic [15:0] addr,
                             input logic [15:0] wdata, output int g_cyc, output int d_cyc,
                             output logic err, output logic [15:0] rdata);
        g_cyc = -1; d_cyc = -1; err = 1'bx; rdata = 'x;
        set_port(is_dma, 1'b1, we, addr, wdata);
        for (int i = 0; i < 30 && g_cyc < 0; i++) begin
            @(negedge Clock);
            if (is_dma ? dma_gnt : cpu_gnt) g_cyc = pcyc;
        end
        @(posedge Clock); #1;
        set_port(is_dma, 1'b0, 1'b0, 16'h0, 16'h0);
        if (g_cyc < 0) begin
            fail_timeout("access_gnt");
            return;
        end
        for (int i = 0; i < 10 && d_cyc < 0; i++) begin
            @(negedge Clock);
            if (is_dma ? dma_done : cpu_done) begin
                d_cyc = pcyc;
                err   = is_dma ? dma_err   : cpu_err;
                rdata = is_dma ? dma_rdata : cpu_rdata;
            end
        end
        if (d_cyc < 0) fail_timeout("access_done");
        @(posedge Clock); #1;
    endtask

    // Back-to-back reads with req held high across grants.
    task automatic stream(input bit is_dma, input int n);
        for (int i = 0; i < n; i++) begin
            bit got = 1'b0;
            set_port(is_dma, 1'b1, 1'b0, 16'(8 * i + (is_dma ? 4 : 0)), 16'h0);
            for (int j = 0; j < 40 && !got; j++) begin
                @(negedge Clock);
                got = is_dma ? dma_gnt : cpu_gnt;
            end
            if (!got) fail_timeout("stream_gnt");
            @(posedge Clock); #1;
        end
        set_port(is_dma, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    // Randomized requester; occasionally withdraws a request before its grant.
    task automatic run_port(input bit is_dma, input int n);
        @(posedge Clock); #1;
        for (int i = 0; i < n; i++) begin
            int          gap  = $urandom_range(0, 3);
            int          pick = $urandom_range(0, 9);
            bit          drop = ($urandom_range(0, 7) == 0);
            bit          got = 1'b0, dropped = 1'b0;
            logic [15:0] a;
            case (pick)
                0:       a = 16'($urandom_range(0, 127)) | 16'h0001;
                1:       a = 16'h007E;
                2:       a = 16'h0080 + 16'($urandom_range(0, 32000) * 2);
                default: a = 16'($urandom_range(0, 63) * 2);
            endcase
            repeat (gap) begin @(posedge Clock); #1; end
            set_port(is_dma, 1'b1, 1'($urandom), a, 16'($urandom));
            for (int j = 0; j < 60 && !got && !dropped; j++) begin
                @(negedge Clock);
                got = is_dma ? dma_gnt : cpu_gnt;
                if (!got && drop) begin
                    @(posedge Clock); #1;
                    set_port(is_dma, 1'b0, 1'b0, 16'h0, 16'h0);
                    dropped = 1'b1;
                end
            end
            if (got) begin
                @(posedge Clock); #1;
                set_port(is_dma, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
            end else if (!dropped) begin
                fail_timeout("random_gnt");
                set_port(is_dma, 1'b0, 1'b0, 16'h0, 16'h0);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        int          g, d, wc0, rc0, cd0;
        logic        e;
        logic [15:0] r;

        for (int i = 0; i < MEM_BYTES; i++) begin
            phys_mem[i] = 8'(i * 7 + 3);
            ref_mem[i]  = 8'(i * 7 + 3);
        end

        // Reset state, with both requests held high through reset.
        set_port(1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
        set_port(1'b1, 1'b1, 1'b0, 16'h0, 16'h0);
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check("reset_outputs",
              {cpu_gnt, cpu_done, cpu_err, cpu_rdata, dma_gnt, dma_done, dma_err, dma_rdata,
               mem_MemWrite, mem_MemRead, busy},
              64'h0);
        check("reset_mem_bus", {mem_Adresa, mem_WriteData}, 64'h0);
        set_port(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        set_port(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        @(posedge Clock); #1;
        Reset_n = 1'b1;
        @(posedge Clock); #1;

        // CPU write 0xBEEF to 0x0010.
        wc0 = wr_cnt;
        do_access(1'b0, 1'b1, 16'h0010, 16'hBEEF, g, d, e, r);
        check("cpu_wr_latency", d - g, 3);
        check("cpu_wr_err", e, 0);
        check("cpu_wr_strobe_count", wr_cnt - wc0, 1);
        check("cpu_wr_strobe_cycle", last_wr_cyc - g, 1);
        check("mem_byte_0x10", phys_mem[16], 8'hBE);
        check("mem_byte_0x11", phys_mem[17], 8'hEF);

        // DMA read of the same word; the CPU sees no done.
        rc0 = rd_cnt; cd0 = cpu_done_cnt;
        do_access(1'b1, 1'b0, 16'h0010, 16'h0000, g, d, e, r);
        check("dma_rd_latency", d - g, 3);
        check("dma_rd_err", e, 0);
        check("dma_rd_data", r, 16'hBEEF);
        check("dma_rd_strobe_count", rd_cnt - rc0, 1);
        check("dma_rd_strobe_cycle", last_rd_cyc - g, 1);
        check("cpu_done_quiet", cpu_done_cnt - cd0, 0);

        // Rejected: odd address and out of range; no strobe at all.
        wc0 = wr_cnt; rc0 = rd_cnt;
        do_access(1'b0, 1'b0, 16'h0011, 16'h0000, g, d, e, r);
        check("odd_latency", d - g, 1);
        check("odd_err", e, 1);
        do_access(1'b0, 1'b0, 16'h007F, 16'h0000, g, d, e, r);
        check("range_latency", d - g, 1);
        check("range_err", e, 1);
        do_access(1'b0, 1'b1, 16'h0100, 16'h5555, g, d, e, r);
        check("range_wr_err", e, 1);
        check("rejected_no_strobes", (wr_cnt - wc0) + (rd_cnt - rc0), 0);

        // Last legal word.
        do_access(1'b0, 1'b1, 16'h007E, 16'h1234, g, d, e, r);
        check("last_word_wr_err", e, 0);
        do_access(1'b1, 1'b0, 16'h007E, 16'h0000, g, d, e, r);
        check("last_word_rd_err", e, 0);
        check("last_word_rd_data", r, 16'h1234);

        // Reset during RESP of a CPU read: everything drops at once, no done.
        set_port(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0);
        g = -1;
        for (int i = 0; i < 20 && g < 0; i++) begin
            @(negedge Clock);
            if (cpu_gnt) g = pcyc;
        end
        if (g < 0) fail_timeout("abort_gnt");
        @(posedge Clock); #1;
        set_port(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(posedge Clock); #2;
        check("resp_busy_before_reset", busy, 1);
        cd0 = cpu_done_cnt;
        Reset_n = 1'b0;
        #1;
        check("reset_abort_async", {busy, mem_MemWrite, mem_MemRead, cpu_done}, 0);

        // Tie pending through reset: CPU must win first, then strict alternation.
        set_port(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0);
        set_port(1'b1, 1'b1, 1'b0, 16'h0004, 16'h0);
        repeat (3) @(posedge Clock);
        check("reset_abort_no_done", cpu_done_cnt - cd0, 0);
        gq_port.delete();
        gq_cyc.delete();
        #1;
        Reset_n = 1'b1;
        fork
            stream(1'b0, 3);
            stream(1'b1, 3);
        join
        check("tie_grant_count", gq_port.size(), 6);
        for (int k = 0; k < gq_port.size() && k < 6; k++) begin
            check($sformatf("tie_grant_%0d_port", k), gq_port[k], k % 2);
            if (k > 0) check($sformatf("tie_grant_%0d_gap", k), gq_cyc[k] - gq_cyc[k - 1], 4);
        end
        repeat (4) @(posedge Clock); #1;

        // Randomized contention on both ports.
        fork
            run_port(1'b0, 40);
            run_port(1'b1, 40);
        join
        repeat (6) @(posedge Clock);
        @(negedge Clock); #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
